// File: rtl/ecc_bank_responder_if.sv
// Initiator bus of the ECC bank responder.
// Member names carry the responder-side direction suffixes.
interface ecc_bank_responder_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 8
);
    logic                   req_i;
    logic                   we_i;
    logic [DataWidth/8-1:0] be_i;
    logic [AddrWidth-1:0]   add_i;
    logic [DataWidth-1:0]   wdata_i;
    logic                   gnt_o;
    logic [DataWidth-1:0]   rdata_o;
    logic                   single_err_o;
    logic                   multi_err_o;

    modport master (
        output req_i, we_i, be_i, add_i, wdata_i,
        input  gnt_o, rdata_o, single_err_o, multi_err_o
    );

    modport slave (
        input  req_i, we_i, be_i, add_i, wdata_i,
        output gnt_o, rdata_o, single_err_o, multi_err_o
    );
endinterface

// File: rtl/ecc_bank_responder.sv
// SECDED (Hsiao) protected SRAM bank responder with byte-enable RMW.
// Optional correction write-back of read data: ECC_BANK_WRITEBACK_EN.
module ecc_bank_responder #(
    parameter int DataWidth = 32,
    parameter int ProtWidth = 39,
    parameter int Depth     = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ecc_bank_responder_if.slave        bus,
    output logic                       sram_req_o,
    output logic                       sram_we_o,
    output logic [$clog2(Depth)-1:0]   sram_add_o,
    output logic [ProtWidth-1:0]       sram_wdata_o,
    input  logic [ProtWidth-1:0]       sram_rdata_i
);
    localparam int AddrWidth = $clog2(Depth);
    localparam int ChkWidth  = ProtWidth - DataWidth;
    localparam int NumBytes  = DataWidth / 8;

    typedef enum logic [1:0] {
        Idle,
        Resp,
        Rmw,
        WriteBack
    } state_e;

    // Hsiao columns: odd weight >= 3, lowest weight first, ascending value.
    function automatic logic [DataWidth*ChkWidth-1:0] gen_hsiao();
        logic [DataWidth*ChkWidth-1:0] m;
        int n;
        m = '0;
        n = 0;
        for (int w = 3; w <= ChkWidth; w += 2) begin
            for (int v = 1; v < (1 << ChkWidth); v++) begin
                if ($countones(v) == w && n < DataWidth) begin
                    m[n*ChkWidth +: ChkWidth] = v[ChkWidth-1:0];
                    n++;
                end
            end
        end
        return m;
    endfunction

    localparam logic [DataWidth*ChkWidth-1:0] HMat = gen_hsiao();

    function automatic logic [ChkWidth-1:0] chk(input logic [DataWidth-1:0] d);
        logic [ChkWidth-1:0] c;
        c = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (d[i]) c = c ^ HMat[i*ChkWidth +: ChkWidth];
        end
        return c;
    endfunction

    function automatic logic [ProtWidth-1:0] enc(input logic [DataWidth-1:0] d);
        return {chk(d), d};
    endfunction

    state_e                r_state;
    state_e                w_state_d;
    logic [AddrWidth-1:0]  r_add;
    logic [NumBytes-1:0]   r_be;
    logic [DataWidth-1:0]  r_wdata;
    logic [DataWidth-1:0]  r_rdata;

    logic [ChkWidth-1:0]   w_syn;
    logic [DataWidth-1:0]  w_dec_data;
    logic [DataWidth-1:0]  w_merge;
    logic                  w_dec_single;
    logic                  w_dec_multi;
    logic                  w_accept;
    logic                  w_gnt;
    logic                  w_lat;
    logic                  w_wb_lat;
    logic                  w_single;
    logic                  w_multi;

    // Decode the word returned by the SRAM and build the RMW merge.
    always_comb begin
        w_syn        = chk(sram_rdata_i[DataWidth-1:0])
                     ^ sram_rdata_i[ProtWidth-1:DataWidth];
        w_dec_single = ^w_syn;
        w_dec_multi  = (w_syn != '0) && !(^w_syn);
        w_dec_data   = sram_rdata_i[DataWidth-1:0];
        for (int i = 0; i < DataWidth; i++) begin
            if (w_syn == HMat[i*ChkWidth +: ChkWidth]) begin
                w_dec_data[i] = ~w_dec_data[i];
            end
        end
        w_merge = w_dec_data;
        for (int b = 0; b < NumBytes; b++) begin
            if (r_be[b]) w_merge[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    // Next state, grant and SRAM command.
    always_comb begin
        w_state_d    = r_state;
        w_accept     = 1'b0;
        w_gnt        = 1'b0;
        w_lat        = 1'b0;
        w_wb_lat     = 1'b0;
        w_single     = 1'b0;
        w_multi      = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_add_o   = '0;
        sram_wdata_o = '0;

        unique case (r_state)
            Idle: begin
                w_accept = 1'b1;
            end
            Resp: begin
                w_single = w_dec_single;
                w_multi  = w_dec_multi;
`ifdef ECC_BANK_WRITEBACK_EN
                if (w_dec_single) begin
                    w_state_d = WriteBack;
                    w_wb_lat  = 1'b1;
                end else begin
                    w_accept = 1'b1;
                end
`else
                w_accept = 1'b1;
`endif
            end
            Rmw: begin
                w_single  = w_dec_single;
                w_multi   = w_dec_multi;
                w_state_d = Idle;
                if (!w_dec_multi) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_add_o   = r_add;
                    sram_wdata_o = enc(w_merge);
                end
            end
            WriteBack: begin
                w_state_d    = Idle;
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_add_o   = r_add;
                sram_wdata_o = enc(r_wdata);
            end
            default: begin
                w_state_d = Idle;
            end
        endcase

        if (w_accept) begin
            w_state_d = Idle;
            if (bus.req_i && rst_ni) begin
                w_gnt = 1'b1;
                if (!bus.we_i) begin
                    sram_req_o = 1'b1;
                    sram_add_o = bus.add_i;
                    w_lat      = 1'b1;
                    w_state_d  = Resp;
                end else if (&bus.be_i) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_add_o   = bus.add_i;
                    sram_wdata_o = enc(bus.wdata_i);
                end else if (|bus.be_i) begin
                    sram_req_o = 1'b1;
                    sram_add_o = bus.add_i;
                    w_lat      = 1'b1;
                    w_state_d  = Rmw;
                end
            end
        end
    end

    // State register and request latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_add   <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_lat) begin
                r_add   <= bus.add_i;
                r_be    <= bus.be_i;
                r_wdata <= bus.wdata_i;
            end else if (w_wb_lat) begin
                r_wdata <= w_dec_data;
            end
        end
    end

    // Remember the last read response so rdata_o holds between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (r_state == Resp) begin
            r_rdata <= w_dec_data;
        end
    end

    assign bus.gnt_o        = w_gnt;
    assign bus.rdata_o      = (r_state == Resp) ? w_dec_data : r_rdata;
    assign bus.single_err_o = w_single;
    assign bus.multi_err_o  = w_multi;
endmodule

// File: tb/tb_ecc_bank_responder.sv
// Randomised and directed bench for ecc_bank_responder.
// Behavioural SRAM plus a data-level model of bank contents.
module tb_ecc_bank_responder;
    localparam int DW  = 32;
    localparam int PW  = 39;
    localparam int DEP = 256;
    localparam int AW  = 8;
    localparam int K   = PW - DW;

`ifdef ECC_BANK_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ecc_bank_responder_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_add;
    logic [PW-1:0] sram_wdata;
    logic [PW-1:0] sram_rdata;

    ecc_bank_responder #(
        .DataWidth(DW),
        .ProtWidth(PW),
        .Depth    (DEP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_add_o  (sram_add),
        .sram_wdata_o(sram_wdata),
        .sram_rdata_i(sram_rdata)
    );

    int tests = 0;
    int fails = 0;

    logic [PW-1:0] mem [DEP];
    int            wr_cnt = 0;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [PW-1:0] poke_v = '0;

    // Behavioural 1-cycle-latency SRAM; pokes let the bench corrupt words.
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_v;
        if (sram_req) begin
            if (sram_we) begin
                mem[sram_add] <= sram_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                sram_rdata <= mem[sram_add];
            end
        end
    end

    logic [K-1:0]  cols [DW];
    logic [DW-1:0] mdata [16];
    bit            flipped [16];
    logic [DW-1:0] exp_rdata;

    task automatic build_cols();
        int n = 0;
        for (int c = 2; c < K; c++)
            for (int b = 1; b < c; b++)
                for (int a = 0; a < b; a++) begin
                    logic [K-1:0] v;
                    v = '0;
                    v[a] = 1'b1;
                    v[b] = 1'b1;
                    v[c] = 1'b1;
                    if (n < DW) cols[n] = v;
                    n++;
                end
    endtask

    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        logic [K-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) if (d[i]) c = c ^ cols[i];
        return {c, d};
    endfunction

    function automatic logic [PW-1:0] bitm(input int n);
        logic [PW-1:0] one;
        one = 1;
        return one << n;
    endfunction

    task automatic idle();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = '0;
        bus.add_i   = '0;
        bus.wdata_i = '0;
    endtask

    task automatic drive(input logic we, input logic [3:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.be_i    = be;
        bus.add_i   = a;
        bus.wdata_i = d;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [PW-1:0] v);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = a;
        poke_v  = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 8'd3, '0);
        @(negedge clk);
        #1;
        tests++;
        if ({bus.gnt_o, sram_req, sram_we} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000",
                     {bus.gnt_o, sram_req, sram_we});
        end
        tests++;
        if ({bus.rdata_o, bus.single_err_o, bus.multi_err_o} !== 34'h0) begin
            fails++;
            $display("FAIL reset_resp: got %h expected 0",
                     {bus.rdata_o, bus.single_err_o, bus.multi_err_o});
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(1'b1, 4'hF, 8'd5, 32'hDEADBEEF);
        #1;
        tests++;
        if ({bus.gnt_o, sram_req, sram_we, sram_add, sram_wdata}
            !== {3'b111, 8'd5, enc(32'hDEADBEEF)}) begin
            fails++;
            $display("FAIL full_write: got %h expected %h",
                     {bus.gnt_o, sram_req, sram_we, sram_add, sram_wdata},
                     {3'b111, 8'd5, enc(32'hDEADBEEF)});
        end
        @(negedge clk);
        drive(1'b0, 4'h0, 8'd5, '0);
        #1;
        tests++;
        if ({bus.single_err_o, bus.multi_err_o, bus.gnt_o, sram_req,
             sram_we, sram_add} !== {4'b0011, 1'b0, 8'd5}) begin
            fails++;
            $display("FAIL read_issue: got %h expected %h",
                     {bus.single_err_o, bus.multi_err_o, bus.gnt_o,
                      sram_req, sram_we, sram_add}, {4'b0011, 1'b0, 8'd5});
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if ({bus.rdata_o, bus.single_err_o, bus.multi_err_o}
            !== {32'hDEADBEEF, 2'b00}) begin
            fails++;
            $display("FAIL read_resp: got %h expected %h",
                     {bus.rdata_o, bus.single_err_o, bus.multi_err_o},
                     {32'hDEADBEEF, 2'b00});
        end
        @(negedge clk);
        #1;
        tests++;
        if ({bus.rdata_o, bus.single_err_o, bus.multi_err_o}
            !== {32'hDEADBEEF, 2'b00}) begin
            fails++;
            $display("FAIL rdata_hold: got %h expected %h",
                     {bus.rdata_o, bus.single_err_o, bus.multi_err_o},
                     {32'hDEADBEEF, 2'b00});
        end
    endtask

    task automatic test_single_err();
        int w0;
        logic [PW-1:0] bad;
        bad = enc(32'hDEADBEEF) ^ bitm(3);
        poke(8'd5, bad);
        @(negedge clk);
        drive(1'b0, 4'h0, 8'd5, '0);
        @(negedge clk);
        drive(1'b1, 4'h0, 8'd0, '0);
        w0 = wr_cnt;
        #1;
        tests++;
        if ({bus.rdata_o, bus.single_err_o, bus.multi_err_o, bus.gnt_o}
            !== {32'hDEADBEEF, 2'b10, !WB}) begin
            fails++;
            $display("FAIL single_resp: got %h expected %h",
                     {bus.rdata_o, bus.single_err_o, bus.multi_err_o,
                      bus.gnt_o}, {32'hDEADBEEF, 2'b10, !WB});
        end
        @(negedge clk);
        #1;
        tests++;
        if (WB && {bus.gnt_o, sram_req, sram_we, sram_add, sram_wdata}
                  !== {3'b011, 8'd5, enc(32'hDEADBEEF)}) begin
            fails++;
            $display("FAIL writeback: got %h expected %h",
                     {bus.gnt_o, sram_req, sram_we, sram_add, sram_wdata},
                     {3'b011, 8'd5, enc(32'hDEADBEEF)});
        end else if (!WB && sram_req !== 1'b0) begin
            fails++;
            $display("FAIL no_writeback: got sram_req %b expected 0",
                     sram_req);
        end
        idle();
        @(negedge clk);
        #1;
        tests++;
        if ({wr_cnt - w0, mem[5]}
            !== {WB ? 32'd1 : 32'd0, WB ? enc(32'hDEADBEEF) : bad}) begin
            fails++;
            $display("FAIL single_mem: got %h expected %h",
                     {wr_cnt - w0, mem[5]},
                     {WB ? 32'd1 : 32'd0, WB ? enc(32'hDEADBEEF) : bad});
        end
    endtask

    task automatic test_multi_err();
        int w0;
        logic [PW-1:0] bad;
        bad = enc(32'hDEADBEEF) ^ bitm(3) ^ bitm(9);
        poke(8'd5, bad);
        @(negedge clk);
        drive(1'b0, 4'h0, 8'd5, '0);
        @(negedge clk);
        idle();
        w0 = wr_cnt;
        #1;
        tests++;
        if ({bus.single_err_o, bus.multi_err_o} !== 2'b01) begin
            fails++;
            $display("FAIL multi_flags: got %b expected 01",
                     {bus.single_err_o, bus.multi_err_o});
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if ({wr_cnt - w0, mem[5]} !== {32'd0, bad}) begin
            fails++;
            $display("FAIL multi_nowrite: got %h expected %h",
                     {wr_cnt - w0, mem[5]}, {32'd0, bad});
        end
    endtask

    task automatic test_rmw(input bit corrupt);
        int w0;
        logic [PW-1:0] init;
        init = enc(32'h11223344);
        if (corrupt) init = init ^ bitm(1) ^ bitm(20);
        poke(8'd7, init);
        @(negedge clk);
        drive(1'b1, 4'h5, 8'd7, 32'hAABBCCDD);
        #1;
        tests++;
        if ({bus.gnt_o, sram_req, sram_we, sram_add}
            !== {3'b110, 8'd7}) begin
            fails++;
            $display("FAIL rmw_issue: got %h expected %h",
                     {bus.gnt_o, sram_req, sram_we, sram_add},
                     {3'b110, 8'd7});
        end
        @(negedge clk);
        drive(1'b1, 4'h0, 8'd0, '0);
        w0 = wr_cnt;
        #1;
        tests++;
        if (!corrupt && {bus.gnt_o, sram_req, sram_we, sram_add, sram_wdata,
                         bus.single_err_o, bus.multi_err_o}
                        !== {3'b011, 8'd7, enc(32'h11BB33DD), 2'b00}) begin
            fails++;
            $display("FAIL rmw_write: got %h expected %h",
                     {bus.gnt_o, sram_req, sram_we, sram_add, sram_wdata,
                      bus.single_err_o, bus.multi_err_o},
                     {3'b011, 8'd7, enc(32'h11BB33DD), 2'b00});
        end else if (corrupt && {bus.gnt_o, sram_req, bus.single_err_o,
                                 bus.multi_err_o} !== 4'b0001) begin
            fails++;
            $display("FAIL rmw_multi: got %b expected 0001",
                     {bus.gnt_o, sram_req, bus.single_err_o,
                      bus.multi_err_o});
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        tests++;
        if (mem[7] !== (corrupt ? init : enc(32'h11BB33DD))) begin
            fails++;
            $display("FAIL rmw_mem: got %h expected %h", mem[7],
                     corrupt ? init : enc(32'h11BB33DD));
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [4];
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            poke(AW'(i), enc(d[i]));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 4'h0, AW'(i), '0);
            #1;
            tests++;
            if ({bus.gnt_o, sram_req, sram_we, sram_add}
                !== {3'b110, AW'(i)}) begin
                fails++;
                $display("FAIL b2b_grant%0d: got %h expected %h", i,
                         {bus.gnt_o, sram_req, sram_we, sram_add},
                         {3'b110, AW'(i)});
            end
            if (i > 0) begin
                tests++;
                if ({bus.rdata_o, bus.single_err_o, bus.multi_err_o}
                    !== {d[i-1], 2'b00}) begin
                    fails++;
                    $display("FAIL b2b_resp%0d: got %h expected %h", i - 1,
                             {bus.rdata_o, bus.single_err_o,
                              bus.multi_err_o}, {d[i-1], 2'b00});
                end
            end
        end
        @(negedge clk);
        idle();
        #1;
        tests++;
        if ({bus.rdata_o, bus.single_err_o, bus.multi_err_o}
            !== {d[3], 2'b00}) begin
            fails++;
            $display("FAIL b2b_resp3: got %h expected %h",
                     {bus.rdata_o, bus.single_err_o, bus.multi_err_o},
                     {d[3], 2'b00});
        end
        exp_rdata = d[3];
    endtask

    task automatic test_random();
        for (int a = 0; a < 16; a++) begin
            mdata[a]   = $urandom;
            flipped[a] = 1'b0;
            poke(AW'(a), enc(mdata[a]));
        end
        for (int n = 0; n < 150; n++) begin
            int            a;
            int            op;
            logic [3:0]    be;
            logic [DW-1:0] w;
            logic [DW-1:0] mg;
            a  = $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            be = (op == 1) ? 4'hF : 4'($urandom_range(1, 14));
            w  = $urandom;
            if (!flipped[a] && $urandom_range(0, 5) == 0) begin
                poke(AW'(a), mem[a] ^ bitm($urandom_range(0, PW - 1)));
                flipped[a] = 1'b1;
            end
            @(negedge clk);
            drive(op != 0, (op == 3) ? 4'h0 : be, AW'(a), w);
            #1;
            tests++;
            if ({bus.gnt_o, sram_req, sram_we}
                !== {1'b1, op != 3, op == 1}) begin
                fails++;
                $display("FAIL rnd_grant op%0d: got %b expected %b", op,
                         {bus.gnt_o, sram_req, sram_we},
                         {1'b1, op != 3, op == 1});
            end
            @(negedge clk);
            idle();
            #1;
            mg = mdata[a];
            for (int b = 0; b < 4; b++) if (be[b]) mg[b*8 +: 8] = w[b*8 +: 8];
            tests++;
            if (op == 0 && {bus.rdata_o, bus.single_err_o, bus.multi_err_o}
                           !== {mdata[a], flipped[a], 1'b0}) begin
                fails++;
                $display("FAIL rnd_read a%0d: got %h expected %h", a,
                         {bus.rdata_o, bus.single_err_o, bus.multi_err_o},
                         {mdata[a], flipped[a], 1'b0});
            end else if (op == 2 && {sram_req, sram_we, sram_wdata,
                                     bus.single_err_o, bus.multi_err_o}
                                    !== {2'b11, enc(mg), flipped[a], 1'b0}) begin
                fails++;
                $display("FAIL rnd_rmw a%0d: got %h expected %h", a,
                         {sram_req, sram_we, sram_wdata, bus.single_err_o,
                          bus.multi_err_o}, {2'b11, enc(mg), flipped[a], 1'b0});
            end else if (op != 0 && op != 2 && {bus.single_err_o,
                                                bus.multi_err_o} !== 2'b00) begin
                fails++;
                $display("FAIL rnd_flags op%0d: got %b expected 00", op,
                         {bus.single_err_o, bus.multi_err_o});
            end
            if (op == 0) begin
                exp_rdata = mdata[a];
                if (WB) flipped[a] = 1'b0;
            end else if (op != 3) begin
                mdata[a]   = mg;
                flipped[a] = 1'b0;
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            tests++;
            if (bus.rdata_o !== exp_rdata
                || (!flipped[a] && mem[a] !== enc(mdata[a]))) begin
                fails++;
                $display("FAIL rnd_state a%0d: got %h/%h expected %h/%h", a,
                         bus.rdata_o, mem[a], exp_rdata, enc(mdata[a]));
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        logic [DW-1:0] d;
        d = $urandom;
        poke(8'd9, enc(d));
        @(negedge clk);
        drive(1'b1, 4'h3, 8'd9, ~d);
        @(negedge clk);
        rst_n = 1'b0;
        w0 = wr_cnt;
        drive(1'b1, 4'h3, 8'd9, ~d);
        #1;
        tests++;
        if ({bus.gnt_o, sram_req} !== 2'b00) begin
            fails++;
            $display("FAIL rst_rmw_ctrl: got %b expected 00",
                     {bus.gnt_o, sram_req});
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if ({wr_cnt - w0, mem[9], bus.rdata_o, bus.single_err_o,
             bus.multi_err_o} !== {32'd0, enc(d), 32'h0, 2'b00}) begin
            fails++;
            $display("FAIL rst_rmw_nowrite: got %h expected %h",
                     {wr_cnt - w0, mem[9], bus.rdata_o, bus.single_err_o,
                      bus.multi_err_o}, {32'd0, enc(d), 32'h0, 2'b00});
        end
    endtask

    initial begin
        build_cols();
        idle();
        test_reset();
        test_write_read();
        test_single_err();
        test_multi_err();
        test_rmw(1'b0);
        test_rmw(1'b1);
        test_back_to_back();
        test_random();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
